hazard_sequencer: RTL and testbench

//  Central stall/flush/forward controller for the 5-stage RV32I pipeline. Drives enables and clears
//  for the F/D, D/E, E/M and M/W pipeline registers. Resolves RAW hazards by forwarding and by

---
 rtl/hazard_sequencer.sv | 143 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Stall/flush/forward controller for the 5-stage RV32I pipeline.
//   - Forwarding muxes for the two E-stage ALU operands (M result beats W result).
//   - Load-use stall, taken-branch flush, and multi-cycle data-memory wait.
//   - A registered RUN/MEM_WAIT tracker counts consecutive memory-wait cycles.
//     It raises a sticky MemErr_o when the wait reaches TIMEOUT cycles.
//   - A saturating counter of cycles in which the PC was held.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   Rs1D_i/Rs2D_i               source registers of the D instruction
//   Rs1E_i/Rs2E_i/RdE_i         sources and destination of the E instruction
//   RdM_i/RdW_i, RegWrite*_i    destinations and write enables of M and W
//   ResultSrcE_i                E result select; 2'b01 marks a load
//   PCSrcE_i                    taken branch/jump resolved in E
//   MemReqM_i/MemReadyM_i       data-memory request/complete for the M instruction
//   ForwardAE_o/ForwardBE_o     00 regfile, 01 W result, 10 M ALU result
//   Stall*_o, Flush*_o          pipeline-register holds and clears
//   MemErr_o                    sticky memory-timeout flag (registered)
//   StallCount_o                saturating count of StallF_o cycles (registered)
module hazard_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       Rs1E_i,
    input  logic [4:0]       Rs2E_i,
    input  logic [4:0]       RdE_i,
    input  logic [4:0]       RdM_i,
    input  logic [4:0]       RdW_i,
    input  logic             RegWriteM_i,
    input  logic             RegWriteW_i,
    input  logic [1:0]       ResultSrcE_i,
    input  logic             PCSrcE_i,
    input  logic             MemReqM_i,
    input  logic             MemReadyM_i,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             FlushW_o,
    output logic             MemErr_o,
    output logic [CNT_W-1:0] StallCount_o
);

    // The wait counter saturates at TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d, wcnt_base;
    logic            err_d;
    logic            memstall, lwstall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       rwm, input logic [4:0] rdm,
                                           input logic       rww, input logic [4:0] rdw);
        if (rwm && rdm != 5'd0 && rdm == rs)      return 2'b10;
        else if (rww && rdw != 5'd0 && rdw == rs) return 2'b01;
        else                                      return 2'b00;
    endfunction

    assign memstall = MemReqM_i & ~MemReadyM_i;
    assign lwstall  = (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

    // Combinational pipeline controls, highest priority first.
    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        if (rst) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
            FlushW_o = 1'b1;
        end else begin
            ForwardAE_o = fwd_sel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
            ForwardBE_o = fwd_sel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
            if (memstall) begin
                // Freeze everything up to M; W gets a bubble while M waits.
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end else if (PCSrcE_i) begin
                // The D instruction is squashed, so any load-use on it is moot.
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (lwstall) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    // Memory-wait tracking. A wait always starts counting from zero out of RUN.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        err_d     = MemErr_o;
        wcnt_base = (state_q == RUN) ? '0 : wcnt_q;
        if (memstall) begin
            state_d = MEM_WAIT;
            if (wcnt_base == WC_MAX) err_d  = 1'b1;
            else                     wcnt_d = wcnt_base + WC_W'(1);
        end else begin
            state_d = RUN;
            wcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wcnt_q       <= '0;
            MemErr_o     <= 1'b0;
            StallCount_o <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            MemErr_o <= err_d;
            if (StallF_o && StallCount_o != {CNT_W{1'b1}})
                StallCount_o <= StallCount_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
    localparam int TO = 4;
    localparam int SAT_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0] ResultSrcE;
    logic [1:0] FwdA, FwdB, FwdA2, FwdB2;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic StallF2, StallD2, StallE2, StallM2, FlushD2, FlushE2, FlushW2, MemErr2;
    logic [31:0] Cnt;
    logic [SAT_W-1:0] Cnt2;

    int n_chk = 0;
    int n_fail = 0;

    // Model state: consecutive memory-wait length, sticky error, stall tally.
    int      m_run = 0;
    bit      m_err = 1'b0;
    longint  m_cnt = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
        .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
        .ForwardAE_o(FwdA), .ForwardBE_o(FwdB), .StallF_o(StallF), .StallD_o(StallD),
        .StallE_o(StallE), .StallM_o(StallM), .FlushD_o(FlushD), .FlushE_o(FlushE),
        .FlushW_o(FlushW), .MemErr_o(MemErr), .StallCount_o(Cnt));

    // Narrow-counter instance, used only to observe saturation.
    hazard_sequencer #(.CNT_W(SAT_W), .TIMEOUT(TO)) dut_sat (
        .clk(clk), .rst(rst), .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
        .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
        .ForwardAE_o(FwdA2), .ForwardBE_o(FwdB2), .StallF_o(StallF2), .StallD_o(StallD2),
        .StallE_o(StallE2), .StallM_o(StallM2), .FlushD_o(FlushD2), .FlushE_o(FlushE2),
        .FlushW_o(FlushW2), .MemErr_o(MemErr2), .StallCount_o(Cnt2));

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    // Expected control word from the priority rules: {F,D,E,M stalls, D,E,W flushes}.
    function automatic logic [6:0] ctl();
        bit ms, lw;
        ms = MemReqM && !MemReadyM;
        lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (rst)         return 7'b0000_111;
        if (ms)          return 7'b1111_001;
        if (PCSrcE)      return 7'b0000_110;
        if (lw)          return 7'b1100_010;
        return 7'b0;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [6:0] e;
        e = ctl();
        chk("fwdA", FwdA, rst ? 0 : fwd(Rs1E));
        chk("fwdB", FwdB, rst ? 0 : fwd(Rs2E));
        chk("ctl",  {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, e);
        chk("memerr", MemErr, m_err);
        chk("stallcnt", Cnt, m_cnt);
        chk("stallcnt_sat", Cnt2, (m_cnt > 7) ? 7 : m_cnt);
    end

    always @(posedge clk) begin
        logic [6:0] e;
        e = ctl();
        if (rst) begin
            m_run = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (MemReqM && !MemReadyM) begin
                m_run++;
                if (m_run >= TO) m_err = 1;
            end else m_run = 0;
            if (e[6]) m_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0; #1;
    endtask

    initial begin
        idle(); rst = 1;
        tick(); tick();
        // Reset dominates any hazard inputs.
        RegWriteM = 1; RdM = 5; Rs1E = 5; MemReqM = 1; PCSrcE = 1; #1;
        chk("rst_flushD", FlushD, 1); chk("rst_flushE", FlushE, 1); chk("rst_flushW", FlushW, 1);
        chk("rst_stallF", StallF, 0); chk("rst_stallM", StallM, 0); chk("rst_fwdA", FwdA, 0);
        idle(); rst = 0; #1;
        chk("rst_err", MemErr, 0); chk("rst_cnt", Cnt, 0);

        // Forwarding.
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; #1;
        chk("fwd_m_prio", FwdA, 2);
        RdM = 0; #1;
        chk("fwd_w", FwdA, 1);
        Rs2E = 0; #1;
        chk("fwd_x0", FwdB, 0);
        RdM = 5; Rs2E = 5; #1;
        chk("fwd_b_m", FwdB, 2);
        tick(); idle();

        // Load-use.
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
        chk("lu_stallF", StallF, 1); chk("lu_stallD", StallD, 1);
        chk("lu_flushE", FlushE, 1); chk("lu_flushD", FlushD, 0);
        tick(); idle(); #1;
        chk("lu_cnt", Cnt, 1); chk("lu_release", StallF, 0);

        // Branch beats load-use.
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1; #1;
        chk("br_flushD", FlushD, 1); chk("br_flushE", FlushE, 1); chk("br_stallF", StallF, 0);
        tick(); idle();

        // Three-cycle memory wait.
        do_reset();
        MemReqM = 1; MemReadyM = 0; #1;
        chk("mw_stallF", StallF, 1); chk("mw_stallM", StallM, 1);
        chk("mw_flushW", FlushW, 1); chk("mw_flushD", FlushD, 0);
        tick(); tick(); tick();
        MemReadyM = 1; #1;
        chk("mw_ready_nostall", StallF, 0); chk("mw_ready_flushW", FlushW, 0);
        tick(); idle(); #1;
        chk("mw_cnt", Cnt, 3); chk("mw_err", MemErr, 0);

        // Timeout with TIMEOUT=4.
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        tick(); tick(); tick(); #1;
        chk("to_err_before", MemErr, 0);
        tick();
        chk("to_err_rise", MemErr, 1);
        MemReadyM = 1; tick(); idle(); tick();
        chk("to_err_sticky", MemErr, 1);
        rst = 1; MemReqM = 1; #1;
        chk("to_rst_flushD", FlushD, 1); chk("to_rst_flushW", FlushW, 1);
        tick(); rst = 0; idle(); #1;
        chk("to_rst_err", MemErr, 0); chk("to_rst_cnt", Cnt, 0);

        // Saturation on the narrow counter.
        MemReqM = 1; MemReadyM = 0;
        repeat (10) tick();
        chk("sat_narrow", Cnt2, 7); chk("sat_wide", Cnt, 10);
        do_reset();

        // Randomized traffic, small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            ResultSrcE = 2'($urandom); PCSrcE = ($urandom_range(0, 4) == 0);
            MemReqM = ($urandom_range(0, 2) == 0); MemReadyM = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; idle(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
